// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit.
// MC_CTRL_JAL_EN adds jal (opcode 03) and the JALWB state.
package multicycle_ctrl_pkg;

    localparam logic [5:0] INSTR_RTYPE_OP = 6'h00;
    localparam logic [5:0] INSTR_J_OP     = 6'h02;
    localparam logic [5:0] INSTR_JAL_OP   = 6'h03;
    localparam logic [5:0] INSTR_BEQ_OP   = 6'h04;
    localparam logic [5:0] INSTR_ORI_OP   = 6'h0d;
    localparam logic [5:0] INSTR_LUI_OP   = 6'h0f;
    localparam logic [5:0] INSTR_LW_OP    = 6'h23;
    localparam logic [5:0] INSTR_SW_OP    = 6'h2b;

    localparam logic [5:0] INSTR_ADD_FUNCT  = 6'h20;
    localparam logic [5:0] INSTR_ADDU_FUNCT = 6'h21;
    localparam logic [5:0] INSTR_SUB_FUNCT  = 6'h22;
    localparam logic [5:0] INSTR_SUBU_FUNCT = 6'h23;
    localparam logic [5:0] INSTR_AND_FUNCT  = 6'h24;
    localparam logic [5:0] INSTR_OR_FUNCT   = 6'h25;
    localparam logic [5:0] INSTR_SLT_FUNCT  = 6'h2a;

    localparam logic [4:0] ALUOp_ADDU = 5'd0;
    localparam logic [4:0] ALUOp_ADD  = 5'd1;
    localparam logic [4:0] ALUOp_SUBU = 5'd2;
    localparam logic [4:0] ALUOp_SUB  = 5'd3;
    localparam logic [4:0] ALUOp_AND  = 5'd4;
    localparam logic [4:0] ALUOp_OR   = 5'd5;
    localparam logic [4:0] ALUOp_SLT  = 5'd6;

    localparam logic [1:0] EXT_ZERO    = 2'd0;
    localparam logic [1:0] EXT_SIGNED  = 2'd1;
    localparam logic [1:0] EXT_HIGHPOS = 2'd2;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] REG_DST_RD = 2'd0;
    localparam logic [1:0] REG_DST_RT = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] ALU_B_RT      = 2'd0;
    localparam logic [1:0] ALU_B_FOUR    = 2'd1;
    localparam logic [1:0] ALU_B_IMM     = 2'd2;
    localparam logic [1:0] ALU_B_IMM_SH2 = 2'd3;

`ifdef MC_CTRL_JAL_EN
    typedef enum logic [2:0] {
        MC_S_FETCH  = 3'd0,
        MC_S_DECODE = 3'd1,
        MC_S_EXEC   = 3'd2,
        MC_S_MEM    = 3'd3,
        MC_S_WB     = 3'd4,
        MC_S_JALWB  = 3'd5
    } mc_state_e;
`else
    typedef enum logic [2:0] {
        MC_S_FETCH  = 3'd0,
        MC_S_DECODE = 3'd1,
        MC_S_EXEC   = 3'd2,
        MC_S_MEM    = 3'd3,
        MC_S_WB     = 3'd4
    } mc_state_e;
`endif

    function automatic logic legal_op(input logic [5:0] op);
        case (op)
            INSTR_RTYPE_OP, INSTR_J_OP, INSTR_BEQ_OP, INSTR_ORI_OP,
            INSTR_LUI_OP, INSTR_LW_OP, INSTR_SW_OP: return 1'b1;
`ifdef MC_CTRL_JAL_EN
            INSTR_JAL_OP: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// R-type funct to ALU operation decode; funct_valid flags supported functs.
module mc_alu_decode
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 5
) (
    input  logic [5:0]         funct,
    output logic [ALUOP_W-1:0] alu_ctrl,
    output logic               funct_valid
);

    always_comb begin
        alu_ctrl    = ALUOP_W'(ALUOp_ADDU);
        funct_valid = 1'b1;
        case (funct)
            INSTR_ADDU_FUNCT: alu_ctrl = ALUOP_W'(ALUOp_ADDU);
            INSTR_ADD_FUNCT:  alu_ctrl = ALUOP_W'(ALUOp_ADD);
            INSTR_SUBU_FUNCT: alu_ctrl = ALUOP_W'(ALUOp_SUBU);
            INSTR_SUB_FUNCT:  alu_ctrl = ALUOP_W'(ALUOp_SUB);
            INSTR_AND_FUNCT:  alu_ctrl = ALUOP_W'(ALUOp_AND);
            INSTR_OR_FUNCT:   alu_ctrl = ALUOP_W'(ALUOp_OR);
            INSTR_SLT_FUNCT:  alu_ctrl = ALUOP_W'(ALUOp_SLT);
            default:          funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/exec/mem/wb over a shared ALU and memory port.
// MC_CTRL_JAL_EN enables jal via an extra JALWB state.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 5,
    parameter int unsigned EXTOP_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic               reg_we,
    output logic [1:0]         reg_dst,
    output logic               mem2reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [EXTOP_W-1:0] ext_op,
    output logic [ALUOP_W-1:0] alu_ctrl,
    output logic               illegal,
    output logic               instr_done
);

    mc_state_e state_q, state_d;

    logic [ALUOP_W-1:0] funct_alu;
    logic               funct_valid;
    logic               op_legal;

    mc_alu_decode #(
        .ALUOP_W(ALUOP_W)
    ) u_alu_decode (
        .funct      (funct),
        .alu_ctrl   (funct_alu),
        .funct_valid(funct_valid)
    );

    assign op_legal = legal_op(opcode) && ((opcode != INSTR_RTYPE_OP) || funct_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MC_S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore decode; only pc_we/ir_we/instr_done (and the branch) look at mem_ready/zero.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_SRC_ALU;
        reg_we     = 1'b0;
        reg_dst    = REG_DST_RD;
        mem2reg    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALU_B_RT;
        ext_op     = EXTOP_W'(EXT_ZERO);
        alu_ctrl   = ALUOP_W'(ALUOp_ADDU);
        illegal    = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            MC_S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = ALU_B_FOUR;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = MC_S_DECODE;
                end
            end
            MC_S_DECODE: begin
                alu_src_b = ALU_B_IMM_SH2;
                ext_op    = EXTOP_W'(EXT_SIGNED);
                alu_ctrl  = ALUOP_W'(ALUOp_ADD);
                if (!op_legal) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = MC_S_FETCH;
                end else if (opcode == INSTR_J_OP) begin
                    pc_we      = 1'b1;
                    pc_src     = PC_SRC_JUMP;
                    instr_done = 1'b1;
                    state_d    = MC_S_FETCH;
`ifdef MC_CTRL_JAL_EN
                end else if (opcode == INSTR_JAL_OP) begin
                    // PC is already incremented, so ALUOut captures the return address.
                    alu_src_b = ALU_B_FOUR;
                    ext_op    = EXTOP_W'(EXT_ZERO);
                    alu_ctrl  = ALUOP_W'(ALUOp_ADDU);
                    pc_we     = 1'b1;
                    pc_src    = PC_SRC_JUMP;
                    state_d   = MC_S_JALWB;
`endif
                end else begin
                    state_d = MC_S_EXEC;
                end
            end
            MC_S_EXEC: begin
                // Operand A is rs for every EXEC operation (lui relies on rs being $0).
                alu_src_a = 1'b1;
                state_d   = MC_S_WB;
                case (opcode)
                    INSTR_RTYPE_OP: begin
                        alu_src_b = ALU_B_RT;
                        alu_ctrl  = funct_alu;
                    end
                    INSTR_ORI_OP: begin
                        alu_src_b = ALU_B_IMM;
                        ext_op    = EXTOP_W'(EXT_ZERO);
                        alu_ctrl  = ALUOP_W'(ALUOp_OR);
                    end
                    INSTR_LUI_OP: begin
                        alu_src_b = ALU_B_IMM;
                        ext_op    = EXTOP_W'(EXT_HIGHPOS);
                        alu_ctrl  = ALUOP_W'(ALUOp_OR);
                    end
                    INSTR_LW_OP, INSTR_SW_OP: begin
                        alu_src_b = ALU_B_IMM;
                        ext_op    = EXTOP_W'(EXT_SIGNED);
                        alu_ctrl  = ALUOP_W'(ALUOp_ADD);
                        state_d   = MC_S_MEM;
                    end
                    INSTR_BEQ_OP: begin
                        alu_src_b  = ALU_B_RT;
                        alu_ctrl   = ALUOP_W'(ALUOp_SUB);
                        pc_src     = PC_SRC_ALUOUT;
                        pc_we      = zero;
                        instr_done = 1'b1;
                        state_d    = MC_S_FETCH;
                    end
                    default: state_d = MC_S_FETCH;
                endcase
            end
            MC_S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (opcode == INSTR_SW_OP);
                if (mem_ready) begin
                    if (opcode == INSTR_SW_OP) begin
                        instr_done = 1'b1;
                        state_d    = MC_S_FETCH;
                    end else begin
                        state_d = MC_S_WB;
                    end
                end
            end
            MC_S_WB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
                state_d    = MC_S_FETCH;
                if (opcode == INSTR_LW_OP) begin
                    mem2reg = 1'b1;
                    reg_dst = REG_DST_RT;
                end else if (opcode != INSTR_RTYPE_OP) begin
                    reg_dst = REG_DST_RT;
                end
            end
`ifdef MC_CTRL_JAL_EN
            MC_S_JALWB: begin
                reg_we     = 1'b1;
                reg_dst    = REG_DST_RA;
                instr_done = 1'b1;
                state_d    = MC_S_FETCH;
            end
`endif
            default: state_d = MC_S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver queues per-instruction expectations,
// a monitor accumulates observed control activity and checks it on each instr_done.
module tb_multicycle_ctrl;

    localparam logic [4:0] A_ADDU = 5'd0;
    localparam logic [4:0] A_ADD  = 5'd1;
    localparam logic [4:0] A_SUBU = 5'd2;
    localparam logic [4:0] A_SUB  = 5'd3;
    localparam logic [4:0] A_AND  = 5'd4;
    localparam logic [4:0] A_OR   = 5'd5;
    localparam logic [4:0] A_SLT  = 5'd6;
    localparam logic [4:0] A_NONE = 5'h1f;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, mem2reg, alu_src_a;
    logic       illegal, instr_done;
    logic [1:0] pc_src, reg_dst, alu_src_b, ext_op;
    logic [4:0] alu_ctrl;

    multicycle_ctrl #(
        .ALUOP_W(5),
        .EXTOP_W(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .iord      (iord),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .mem2reg   (mem2reg),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .ext_op    (ext_op),
        .alu_ctrl  (alu_ctrl),
        .illegal   (illegal),
        .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         lat;
        int         ill;
        int         rw;
        logic [1:0] rd;
        logic       m2r;
        int         mw;
        int         pcw;
        logic [1:0] pcs;
        logic [4:0] alu;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   issued = 0;
    int   fwait = 0;
    int   mwait = 0;
    bit   noisy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input string n, input int lat, input int ill, input int rw,
                                input logic [1:0] rd, input logic m2r, input int mw,
                                input int pcw, input logic [1:0] pcs, input logic [4:0] alu);
        exp_t e;
        e.name = n; e.lat = lat; e.ill = ill; e.rw = rw; e.rd = rd; e.m2r = m2r;
        e.mw = mw; e.pcw = pcw; e.pcs = pcs; e.alu = alu;
        return e;
    endfunction

    // Memory model: answers fetch after fwait cycles, data access after mwait cycles.
    initial begin
        int   cnt;
        logic prev_iord;
        cnt = 0;
        prev_iord = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                mem_ready = 1'b0;
                cnt = 0;
            end else if (mem_req) begin
                if (iord != prev_iord) cnt = 0;
                prev_iord = iord;
                if (cnt >= (iord ? mwait : fwait)) begin
                    mem_ready = 1'b1;
                    cnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ready = noisy;
                cnt = 0;
            end
        end
    end

    // Monitor: accumulate per-instruction activity, compare on instr_done.
    initial begin
        int         cyc, ill, rw, mw, pcw;
        logic [1:0] rd, pcs;
        logic       m2r;
        logic [4:0] alu;
        exp_t       e;
        cyc = 0; ill = 0; rw = 0; mw = 0; pcw = 0; rd = 0; pcs = 0; m2r = 0; alu = A_NONE;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc = 0; ill = 0; rw = 0; mw = 0; pcw = 0; rd = 0; pcs = 0; m2r = 0;
                alu = A_NONE;
            end else begin
                cyc++;
                if (illegal) ill++;
                if (reg_we) begin
                    rw++;
                    rd = reg_dst;
                    m2r = mem2reg;
                end
                if (mem_req && mem_we) mw++;
                if (pc_we) begin
                    pcw++;
                    pcs = pc_src;
                end
                if (alu_src_a) alu = alu_ctrl;
                if (instr_done) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_instr_done: got done at cycle %0d, expected none",
                                 cyc);
                    end else begin
                        e = q.pop_front();
                        chk({e.name, "_latency"}, cyc, e.lat);
                        chk({e.name, "_illegal"}, ill, e.ill);
                        chk({e.name, "_reg_we"}, rw, e.rw);
                        if (e.rw > 0) begin
                            chk({e.name, "_reg_dst"}, rd, e.rd);
                            chk({e.name, "_mem2reg"}, m2r, e.m2r);
                        end
                        chk({e.name, "_mem_we"}, mw, e.mw);
                        chk({e.name, "_pc_we"}, pcw, e.pcw);
                        chk({e.name, "_pc_src"}, pcs, e.pcs);
                        chk({e.name, "_exec_alu"}, alu, e.alu);
                    end
                    done_cnt++;
                    cyc = 0; ill = 0; rw = 0; mw = 0; pcw = 0; rd = 0; pcs = 0; m2r = 0;
                    alu = A_NONE;
                end
            end
        end
    end

    // Called at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int fw,
                       input int mw_, input bit nz, input exp_t e);
        bit ok;
        opcode = op; funct = fn; zero = z; fwait = fw; mwait = mw_; noisy = nz;
        q.push_back(e);
        issued++;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (done_cnt == issued) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no instr_done in 60 cycles, expected one", e.name);
            q.delete();
            issued = done_cnt;
            rst_n = 1'b0;
            @(negedge clk);
            #1 rst_n = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_mem_req", mem_req, 1);
        chk("rst_iord", iord, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_alu_src_a", alu_src_a, 0);
        chk("rst_alu_src_b", alu_src_b, 1);
        chk("rst_alu_ctrl", alu_ctrl, A_ADDU);
        chk("rst_ext_op", ext_op, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_ir_we_idle", ir_we, 0);
        chk("rst_pc_we_idle", pc_we, 0);
        chk("rst_instr_done", instr_done, 0);
        chk("rst_illegal", illegal, 0);
        mem_ready = 1'b1;
        #1;
        chk("rst_ir_we_ready", ir_we, 1);
        chk("rst_pc_we_ready", pc_we, 1);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(6'h00, 6'h21, 0, 0, 0, 0, mk("addu", 4, 0, 1, 0, 0, 0, 1, 0, A_ADDU));
        run(6'h00, 6'h23, 0, 1, 0, 0, mk("subu_fwait1", 5, 0, 1, 0, 0, 0, 1, 0, A_SUBU));
        run(6'h00, 6'h22, 0, 0, 0, 1, mk("sub_noisy_ready", 4, 0, 1, 0, 0, 0, 1, 0, A_SUB));
        run(6'h00, 6'h20, 0, 0, 0, 0, mk("add", 4, 0, 1, 0, 0, 0, 1, 0, A_ADD));
        run(6'h00, 6'h24, 0, 0, 0, 0, mk("and", 4, 0, 1, 0, 0, 0, 1, 0, A_AND));
        run(6'h00, 6'h25, 0, 0, 0, 0, mk("or", 4, 0, 1, 0, 0, 0, 1, 0, A_OR));
        run(6'h00, 6'h2a, 0, 0, 0, 0, mk("slt", 4, 0, 1, 0, 0, 0, 1, 0, A_SLT));
        run(6'h0d, 6'h00, 0, 0, 0, 0, mk("ori", 4, 0, 1, 1, 0, 0, 1, 0, A_OR));
        run(6'h0f, 6'h00, 0, 0, 0, 0, mk("lui", 4, 0, 1, 1, 0, 0, 1, 0, A_OR));
        run(6'h23, 6'h00, 0, 0, 0, 0, mk("lw", 5, 0, 1, 1, 1, 0, 1, 0, A_ADD));
        run(6'h23, 6'h00, 0, 0, 2, 0, mk("lw_mwait2", 7, 0, 1, 1, 1, 0, 1, 0, A_ADD));
        run(6'h2b, 6'h00, 0, 0, 0, 0, mk("sw", 4, 0, 0, 0, 0, 1, 1, 0, A_ADD));
        run(6'h2b, 6'h00, 0, 0, 1, 0, mk("sw_mwait1", 5, 0, 0, 0, 0, 2, 1, 0, A_ADD));
        run(6'h04, 6'h00, 1, 0, 0, 0, mk("beq_taken", 3, 0, 0, 0, 0, 0, 2, 1, A_SUB));
        run(6'h04, 6'h00, 0, 0, 0, 0, mk("beq_not_taken", 3, 0, 0, 0, 0, 0, 1, 0, A_SUB));
        run(6'h02, 6'h00, 0, 0, 0, 0, mk("j", 2, 0, 0, 0, 0, 0, 2, 2, A_NONE));
        run(6'h00, 6'h3f, 0, 0, 0, 0, mk("bad_funct", 2, 1, 0, 0, 0, 0, 1, 0, A_NONE));
        run(6'h3f, 6'h00, 0, 0, 0, 0, mk("bad_opcode", 2, 1, 0, 0, 0, 0, 1, 0, A_NONE));
`ifdef MC_CTRL_JAL_EN
        run(6'h03, 6'h00, 0, 0, 0, 0, mk("jal", 3, 0, 1, 2, 0, 0, 2, 2, A_NONE));
`else
        run(6'h03, 6'h00, 0, 0, 0, 0, mk("jal_illegal", 2, 1, 0, 0, 0, 0, 1, 0, A_NONE));
`endif

        // Abort an sw stalled in MEM with an asynchronous reset.
        opcode = 6'h2b; funct = 6'h00; zero = 1'b0; fwait = 0; mwait = 100; noisy = 1'b0;
        begin
            bit in_mem;
            in_mem = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (mem_req && iord) begin
                    in_mem = 1'b1;
                    break;
                end
            end
            chk("sw_reached_mem", in_mem, 1);
            chk("sw_mem_we_before_reset", mem_we, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_req", mem_req, 1);
        chk("abort_iord", iord, 0);
        chk("abort_mem_we", mem_we, 0);
        chk("abort_reg_we", reg_we, 0);
        chk("abort_instr_done", instr_done, 0);
        mwait = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(6'h00, 6'h21, 0, 0, 0, 0, mk("addu_after_abort", 4, 0, 1, 0, 0, 0, 1, 0, A_ADDU));
        run(6'h23, 6'h00, 0, 1, 1, 0, mk("lw_both_waits", 7, 0, 1, 1, 1, 0, 1, 0, A_ADD));

        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
